// File: rtl/chroma_modulator_dds_if.sv
// chroma_modulator_dds_if: sample, control and modulated-output signals of the DDS chroma modulator.
interface chroma_modulator_dds_if #(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 16
);
   logic [PHASE_W-1:0] phase_inc;
   logic               mode_pal;
   logic [DATA_W-1:0]  burst_amp;
   logic [DATA_W-1:0]  i;
   logic [DATA_W-1:0]  q;
   logic               in_valid;
   logic               hsync;
   logic [DATA_W-1:0]  chroma_out;
   logic               out_valid;
   logic               burst_flag;
   logic               line_odd;
   modport master (
      output phase_inc, mode_pal, burst_amp, i, q, in_valid, hsync,
      input  chroma_out, out_valid, burst_flag, line_odd
   );
   modport slave (
      input  phase_inc, mode_pal, burst_amp, i, q, in_valid, hsync,
      output chroma_out, out_valid, burst_flag, line_odd
   );
endinterface

// File: rtl/chroma_modulator_dds.sv
// chroma_modulator_dds: DDS quadrature chroma modulator with colour burst, PAL alternation,
// round/saturate and a 4-clock valid-qualified pipeline.
module chroma_modulator_dds #(
   parameter int DATA_W      = 8,
   parameter int PHASE_W     = 16,
   parameter int LUT_ADDR_W  = 6,
   parameter int BURST_START = 10,
   parameter int BURST_LEN   = 36
) (
   input logic                   clk_master,
   input logic                   rst,
   chroma_modulator_dds_if.slave bus
);
   localparam int N     = 2 ** LUT_ADDR_W;
   localparam int CNT_W = $clog2((BURST_START > BURST_LEN ? BURST_START : BURST_LEN) + 1);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic signed [DATA_W:0]     OFS   = (DATA_W + 1)'(2 ** (DATA_W - 1));
   localparam logic [DATA_W-1:0]          MID   = DATA_W'(2 ** (DATA_W - 1));
   localparam logic signed [2*DATA_W+1:0] RND   = (2 * DATA_W + 2)'(2 ** (DATA_W - 2));
   localparam logic signed [DATA_W+2:0]   R_MAX = (DATA_W + 3)'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [DATA_W+2:0]   R_MIN = (DATA_W + 3)'(-(2 ** (DATA_W - 1)));
   localparam real PI = 3.14159265358979323846;

   function automatic logic signed [DATA_W-1:0] sin_val(input int k);
      real x;
      x = (2.0 ** (DATA_W - 1) - 1.0) * $sin(2.0 * PI * k / (2.0 ** LUT_ADDR_W));
      return DATA_W'($rtoi(x < 0.0 ? x - 0.5 : x + 0.5));
   endfunction

   logic signed [DATA_W-1:0] w_rom [N];
   for (genvar k = 0; k < N; k++) begin : g_rom
      assign w_rom[k] = sin_val(k);
   end

   logic [PHASE_W-1:0]          r_acc;
   logic                        r_hs_d, r_line_odd;
   logic [1:0]                  r_state;
   logic [CNT_W-1:0]            r_cnt;
   logic                        r_s0_v, r_s0_b, r_s1_v, r_s1_b, r_s2_v, r_s2_b, r_ov, r_bf;
   logic signed [DATA_W:0]      r_s0_ie, r_s0_qe, r_s1_ie, r_s1_qe;
   logic [LUT_ADDR_W-1:0]       r_s0_a;
   logic signed [DATA_W-1:0]    r_s1_sin, r_s1_cos;
   logic signed [2*DATA_W:0]    r_s2_pi, r_s2_pq;
   logic [DATA_W-1:0]           r_chroma;

   logic                        w_burst, w_hs_rise, w_hs_fall, w_wait_done, w_burst_done;
   logic [DATA_W-1:0]           w_pal_amp, w_sat;
   logic signed [DATA_W:0]      w_amp, w_pal, w_iv, w_qv, w_ie, w_qe;
   logic [LUT_ADDR_W-1:0]       w_cos_a;
   logic signed [2*DATA_W+1:0]  w_sum;
   logic signed [DATA_W+2:0]    w_r;

   always_comb begin
      w_burst      = r_state == ST_BURST;
      w_hs_rise    = bus.hsync & ~r_hs_d;
      w_hs_fall    = ~bus.hsync & r_hs_d;
      // WAIT is entered one clock after the fall, so it lasts BURST_START-1 clocks
      w_wait_done  = r_cnt == CNT_W'(BURST_START - 2);
      w_burst_done = r_cnt == CNT_W'(BURST_LEN - 1);
      w_pal_amp    = DATA_W'((32'(bus.burst_amp) * 181) >> 8);
      w_amp        = $signed({1'b0, bus.burst_amp});
      w_pal        = $signed({1'b0, w_pal_amp});
      w_iv         = $signed({1'b0, bus.i}) - OFS;
      w_qv         = $signed({1'b0, bus.q}) - OFS;
      w_ie         = !w_burst ? w_iv : bus.mode_pal ? -w_pal : -w_amp;
      w_qe         = !w_burst ? (bus.mode_pal && r_line_odd ? -w_qv : w_qv) :
                     !bus.mode_pal ? '0 : r_line_odd ? -w_pal : w_pal;
      w_cos_a      = r_s0_a + LUT_ADDR_W'(2 ** (LUT_ADDR_W - 2));
      w_sum        = (2 * DATA_W + 2)'(r_s2_pi) + (2 * DATA_W + 2)'(r_s2_pq) + RND;
      w_r          = (DATA_W + 3)'(w_sum >>> (DATA_W - 1));
      w_sat        = w_r > R_MAX ? R_MAX[DATA_W-1:0] : w_r < R_MIN ? R_MIN[DATA_W-1:0] : w_r[DATA_W-1:0];
   end

   always_ff @(posedge clk_master) begin
      if (rst) begin
         r_acc      <= '0;
         r_hs_d     <= 1'b0;
         r_line_odd <= 1'b0;
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
      end else begin
         r_acc      <= bus.hsync ? '0 : r_acc + bus.phase_inc;
         r_hs_d     <= bus.hsync;
         r_line_odd <= r_line_odd ^ w_hs_rise;
         if (bus.hsync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else if (w_hs_fall) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
         end else if (r_state == ST_WAIT) begin
            r_state <= w_wait_done ? ST_BURST : ST_WAIT;
            r_cnt   <= w_wait_done ? '0 : r_cnt + CNT_W'(1);
         end else if (w_burst) begin
            r_state <= w_burst_done ? ST_IDLE : ST_BURST;
            r_cnt   <= w_burst_done ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_master) begin
      if (rst) begin
         {r_s0_v, r_s0_b, r_s1_v, r_s1_b, r_s2_v, r_s2_b, r_ov, r_bf} <= '0;
         r_chroma <= MID;
      end else begin
         r_s0_v   <= bus.in_valid | w_burst;
         r_s0_b   <= w_burst;
         r_s1_v   <= r_s0_v;
         r_s1_b   <= r_s0_b;
         r_s2_v   <= r_s1_v;
         r_s2_b   <= r_s1_b;
         r_ov     <= r_s2_v;
         r_bf     <= r_s2_b;
         r_chroma <= r_s2_v ? w_sat + MID : MID;
      end
   end

   always_ff @(posedge clk_master) begin
      r_s0_ie  <= w_ie;
      r_s0_qe  <= w_qe;
      r_s0_a   <= r_acc[PHASE_W-1 -: LUT_ADDR_W];
      r_s1_ie  <= r_s0_ie;
      r_s1_qe  <= r_s0_qe;
      r_s1_sin <= w_rom[r_s0_a];
      r_s1_cos <= w_rom[w_cos_a];
      r_s2_pi  <= (2 * DATA_W + 1)'(r_s1_ie) * (2 * DATA_W + 1)'(r_s1_cos);
      r_s2_pq  <= (2 * DATA_W + 1)'(r_s1_qe) * (2 * DATA_W + 1)'(r_s1_sin);
   end

   assign bus.chroma_out = r_chroma;
   assign bus.out_valid  = r_ov;
   assign bus.burst_flag = r_bf;
   assign bus.line_odd   = r_line_odd;
endmodule

// File: tb/tb_chroma_modulator_dds.sv
// tb_chroma_modulator_dds: randomized and directed stimulus against a trigonometric reference model,
// with a timestamped scoreboard drained by an independent output monitor.
module tb_chroma_modulator_dds;
   localparam int DW = 8;
   localparam int PW = 16;
   typedef struct {
      int t;
      int c;
      bit b;
   } exp_t;

   logic clk_master = 1'b0;
   logic rst = 1'b1;
   chroma_modulator_dds_if #(.DATA_W(DW), .PHASE_W(PW)) bus ();
   chroma_modulator_dds #(
      .DATA_W(DW), .PHASE_W(PW), .LUT_ADDR_W(6), .BURST_START(10), .BURST_LEN(36)
   ) dut (
      .clk_master(clk_master),
      .rst(rst),
      .bus(bus)
   );

   exp_t sb[$];
   int sin_t[64];
   int checks = 0, errors = 0, cyc = 0, bcnt = 0;
   int m_acc = 0, m_since = -1;
   bit m_odd = 1'b0, m_prevh = 1'b0, mon_en = 1'b0;

   always #5 clk_master = ~clk_master;
   always @(posedge clk_master) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   // Expected chroma from the phase angle (table index = top 6 phase bits) and the current inputs
   function automatic int model(input bit burst, input int a);
      int ie, qe, k, h, s, r;
      h = int'(bus.burst_amp) * 181 / 256;
      if (burst) begin
         ie = bus.mode_pal ? -h : -int'(bus.burst_amp);
         qe = bus.mode_pal ? (m_odd ? -h : h) : 0;
      end else begin
         ie = int'(bus.i) - 128;
         qe = int'(bus.q) - 128;
         if (bus.mode_pal && m_odd) qe = -qe;
      end
      k = a / 1024;
      s = ie * sin_t[(k + 16) % 64] + qe * sin_t[k];
      r = $rtoi($floor((s + 64) / 128.0));
      r = r > 127 ? 127 : r < -128 ? -128 : r;
      return r + 128;
   endfunction

   task automatic tick();
      exp_t e;
      bit burst;
      if (rst) begin
         while (sb.size() > 0 && sb[$].t > cyc) void'(sb.pop_back());
         m_acc = 0;
         m_since = -1;
         m_odd = 1'b0;
         m_prevh = 1'b0;
      end else begin
         burst = m_since >= 10 && m_since < 46;
         if (burst || bus.in_valid) begin
            e.t = cyc + 4;
            e.c = model(burst, m_acc);
            e.b = burst;
            sb.push_back(e);
         end
         m_odd = m_odd ^ (bus.hsync && !m_prevh);
         m_since = bus.hsync ? -1 : m_prevh ? 1 : m_since >= 0 ? m_since + 1 : -1;
         m_acc = bus.hsync ? 0 : (m_acc + int'(bus.phase_inc)) % 65536;
         m_prevh = bus.hsync;
      end
      @(posedge clk_master);
      #1;
      check("line_odd", int'(bus.line_odd), int'(m_odd));
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input int n);
      bus.hsync = 1'b1;
      run(n);
      bus.hsync = 1'b0;
   endtask

   task automatic check_reset();
      check("rst_chroma", int'(bus.chroma_out), 128);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_burst_flag", int'(bus.burst_flag), 0);
      check("rst_line_odd", int'(bus.line_odd), 0);
   endtask

   always @(negedge clk_master) begin
      exp_t e;
      if (mon_en) begin
         if (bus.burst_flag) bcnt++;
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid at cycle %0d: out_valid=1 chroma=%0d, expected no sample", cyc, bus.chroma_out);
            end else begin
               e = sb.pop_front();
               check("latency", cyc, e.t);
               check("chroma", int'(bus.chroma_out), e.c);
               check("burst_flag", int'(bus.burst_flag), int'(e.b));
            end
         end else begin
            check("bubble_chroma", int'(bus.chroma_out), 128);
            check("bubble_burst_flag", int'(bus.burst_flag), 0);
            if (sb.size() > 0 && sb[0].t <= cyc) begin
               e = sb.pop_front();
               checks++;
               errors++;
               $display("FAIL missing_valid at cycle %0d: out_valid=0, expected chroma %0d due at cycle %0d", cyc, e.c, e.t);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 64; k++) begin
         real x;
         x = 127.0 * $sin(2.0 * 3.141592653589793 * k / 64.0);
         sin_t[k] = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
      end
      bus.phase_inc = '0;
      bus.mode_pal = 1'b0;
      bus.burst_amp = '0;
      bus.i = 8'd128;
      bus.q = 8'd128;
      bus.in_valid = 1'b0;
      bus.hsync = 1'b0;
      rst = 1'b1;
      tick();
      mon_en = 1'b1;
      tick();
      check_reset();
      rst = 1'b0;
      // NTSC carrier at quarter-rate subcarrier
      bus.phase_inc = 16'd16384;
      bus.i = 8'd255;
      bus.q = 8'd128;
      bus.in_valid = 1'b1;
      pulse(2);
      run(20);
      // saturation at 45 and 225 degrees
      bus.phase_inc = 16'd8192;
      bus.q = 8'd255;
      pulse(2);
      run(8);
      // NTSC burst only
      bus.phase_inc = 16'd16384;
      bus.burst_amp = 8'd40;
      bus.in_valid = 1'b0;
      bcnt = 0;
      pulse(2);
      run(60);
      check("burst_length", bcnt, 36);
      // PAL alternation over two lines
      bus.mode_pal = 1'b1;
      bus.i = 8'd128;
      bus.q = 8'd228;
      bus.in_valid = 1'b1;
      bus.burst_amp = 8'd60;
      pulse(2);
      run(60);
      pulse(2);
      run(60);
      // hsync arriving mid-burst
      bus.mode_pal = 1'b0;
      bus.in_valid = 1'b0;
      bus.burst_amp = 8'd100;
      pulse(1);
      run(25);
      pulse(3);
      run(60);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 0) bus.mode_pal = 1'($urandom_range(0, 1));
         bus.phase_inc = 16'($urandom_range(0, 65535));
         bus.i = 8'($urandom_range(0, 255));
         bus.q = 8'($urandom_range(0, 255));
         bus.burst_amp = 8'($urandom_range(0, 255));
         bus.in_valid = 1'($urandom_range(0, 3) != 0);
         bus.hsync = ($urandom_range(0, 70) == 0) || (bus.hsync && $urandom_range(0, 2) != 0);
         tick();
      end
      bus.hsync = 1'b0;
      run(4);
      // reset mid-stream with samples and a burst in flight
      bus.in_valid = 1'b1;
      bus.burst_amp = 8'd50;
      bus.phase_inc = 16'd4096;
      pulse(2);
      run(14);
      rst = 1'b1;
      tick();
      check_reset();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bcnt = 0;
      run(30);
      check("no_burst_after_reset", bcnt, 0);
      pulse(1);
      run(55);
      run(8);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/chroma_modulator_dds.md
Name: chroma_modulator_dds

Overview:
- Parametrised successor to the fixed 6-phase chroma modulator.
- A DDS phase accumulator with a sine LUT drives quadrature modulation of offset-binary I/Q (or U/V) onto the colour subcarrier at clk_master.
- Adds internal colour-burst generation, PAL line-alternation mode, rounding and saturation, and a valid-qualified pipeline.
- Sits between the colour-space converter and the composite summer.

Parameters:
- DATA_W, 8: width of I/Q inputs, burst amplitude and chroma output. Offset binary, offset 2^(DATA_W-1).
- PHASE_W, 16: phase accumulator width.
- LUT_ADDR_W, 6: sine LUT address width, giving 2^LUT_ADDR_W entries over one full cycle.
- BURST_START, 10: clocks from hsync falling edge to first burst sample.
- BURST_LEN, 36: number of burst samples.

Ports:
- clk_master  in  1  master clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- phase_inc  in  PHASE_W  accumulator increment per clock. Subcarrier frequency = f_clk*phase_inc/2^PHASE_W.
- mode_pal  in  1  0 = NTSC, 1 = PAL alternation.
- burst_amp  in  DATA_W  burst amplitude, unsigned magnitude.
- i  in  DATA_W  I/U sample, offset binary.
- q  in  DATA_W  Q/V sample, offset binary.
- in_valid  in  1  qualifies i/q this cycle.
- hsync  in  1  line sync, active high.
- chroma_out  out  DATA_W  modulated chroma, offset binary.
- out_valid  out  1  chroma_out carries a real sample.
- burst_flag  out  1  high while the burst window is active, aligned with the burst samples on chroma_out.
- line_odd  out  1  line parity.

Behaviour:
- Reset: a cycle with rst high sets the following on the next edge:
  - accumulator = 0, line_odd = 0, burst counter idle, pipeline cleared;
  - chroma_out = 2^(DATA_W-1) (128 at default), out_valid = 0, burst_flag = 0.
  - rst overrides all other inputs.
- Accumulator:
  - While hsync is high, acc <= 0.
  - Otherwise acc <= acc + phase_inc, wrapping modulo 2^PHASE_W. It advances every clock, independent of in_valid.
  - The sample entering stage 0 uses the pre-update acc value.
- LUT:
  - sin[k] = round((2^(DATA_W-1)-1)*sin(2*pi*k/2^LUT_ADDR_W)), constant ROM.
  - Address = acc[PHASE_W-1 -: LUT_ADDR_W]. cos address = sin address + 2^(LUT_ADDR_W-2), mod 2^LUT_ADDR_W.
- Parity: line_odd toggles on each hsync rising edge (hsync high, previous hsync low). Registered, so it updates the cycle after the edge.
- Burst FSM, states IDLE, WAIT, BURST:
  - Any state goes to WAIT on an hsync falling edge, with count = 0. The counter restarts if an edge arrives mid-burst.
  - WAIT goes to BURST after BURST_START clocks.
  - BURST goes to IDLE after BURST_LEN clocks.
  - hsync high forces IDLE.
- Stage 0 operand select (Ie, Qe signed, DATA_W+1 bits):
  - BURST, NTSC: Ie = -burst_amp, Qe = 0.
  - BURST, PAL: Ie = -(burst_amp*181)>>8, Qe = +(burst_amp*181)>>8 on even lines, negated on odd lines.
  - Else if in_valid: Ie = i - 2^(DATA_W-1), Qe = q - 2^(DATA_W-1). In PAL mode Qe is negated on odd lines.
  - Else: bubble, with valid = 0.
  - Stage valid = in_valid OR burst active.
- Pipeline:
  - Stage 1: LUT lookup.
  - Stage 2: products Ie*cos and Qe*sin.
  - Stage 3: sum = Ie*cos + Qe*sin. Then r = (sum + 2^(DATA_W-2)) >>> (DATA_W-1), an arithmetic shift with round half up. Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then add 2^(DATA_W-1).
- Latency: exactly 4 clocks from stage-0 sample to chroma_out/out_valid. burst_flag is delayed identically.
- Bubbles: when out_valid = 0, chroma_out = 2^(DATA_W-1).
- Sizing: no intermediate overflow. Products are 2*DATA_W+1 bits; the sum is 2*DATA_W+2 bits.

Test Plan:
- Reset: rst high mid-stream → next cycle chroma_out = 128, out_valid = 0, burst_flag = 0, line_odd = 0. No burst until the next hsync fall.
- NTSC carrier: phase_inc = 16384, i = 255, q = 128, in_valid = 1, hsync pulsed once → after 4-cycle latency chroma_out repeats 254, 128, 2, 128.
- Saturation: phase_inc = 8192, i = q = 255 → at 45° sample (90+90 products, 179 pre-clip) chroma_out = 255. At 225° chroma_out = 0.
- NTSC burst: burst_amp = 40, in_valid = 0, phase_inc = 16384, hsync falls → burst_flag high for exactly 36 clocks starting at fall + 10 + 4 latency. Samples at phase 0 = 88, phase 180° = 168. out_valid = 1 only in the window.
- PAL alternation: mode_pal = 1, i = 128, q = 228, sample at 90° → even line 227, next line (line_odd = 1) 29. The burst Q sign flips between lines.
- hsync during burst: second hsync rise mid-burst → acc = 0 while high, burst_flag drops 4 clocks later, counter restarts on the new fall.
